// File: rtl/ahb_dma_regfile.sv
`default_nettype none
// ============================================================================
// ahb_dma_regfile : DMA channel register file, start/done handshake and IRQ
// Revision        : 1.0
// ============================================================================
module ahb_dma_regfile #(
  parameter int CH_NUM = 4,
  parameter int SIZE_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     slave_write_enable,
  input  logic [31:0]              slave_write_address,
  input  logic [31:0]              slave_write_data,
  input  logic                     slave_read_enable,
  input  logic [31:0]              slave_read_address,
  output logic [31:0]              slave_read_data,
  output logic                     slave_error,
  output logic [CH_NUM-1:0]        ch_start,
  output logic [32*CH_NUM-1:0]     ch_src_addr,
  output logic [32*CH_NUM-1:0]     ch_dst_addr,
  output logic [SIZE_W*CH_NUM-1:0] ch_size,
  output logic [4*CH_NUM-1:0]      ch_ctrl,
  input  logic [CH_NUM-1:0]        ch_done,
  input  logic [CH_NUM-1:0]        ch_err,
  output logic                     irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [4:0]  c_ch_end   = 5'(CH_NUM + 2);
  localparam logic [31:0] c_int_bits = ((32'd1 << CH_NUM) - 32'd1) * 32'h0001_0001;

  // Aligned and decoding to INT_STATUS, INT_MASK or an existing channel slot
  function automatic logic addr_hit(input logic [7:0] a);
    addr_hit = (a[1:0] == 2'b00) &&
               ((a[7:2] == 6'd0) || (a[7:2] == 6'd1) ||
                ((a[7:4] >= 4'd2) && ({1'b0, a[7:4]} < c_ch_end)));
  endfunction

  logic [31:0]       r_int_status, w_nxt_status;
  logic [31:0]       r_int_mask,   w_nxt_mask;
  logic [31:0]       r_src  [CH_NUM];
  logic [31:0]       w_nxt_src [CH_NUM];
  logic [31:0]       r_dst  [CH_NUM];
  logic [31:0]       w_nxt_dst [CH_NUM];
  logic [SIZE_W-1:0] r_size [CH_NUM];
  logic [SIZE_W-1:0] w_nxt_size [CH_NUM];
  logic [4:0]        r_cfg  [CH_NUM];
  logic [4:0]        w_nxt_cfg [CH_NUM];
  state_t            r_state [CH_NUM];
  state_t            w_nxt_state [CH_NUM];
  logic [CH_NUM-1:0] r_en, w_nxt_en;

  logic [7:0]  w_wr_a, w_rd_a;
  logic [3:0]  w_wr_idx, w_rd_idx;
  logic        w_wr_hit, w_rd_hit, w_wr_err;
  logic [31:0] w_rd_val;
  logic [31:0] r_rd_data;
  logic        r_err, r_irq;
  logic        w_unused_addr;

  assign w_wr_a        = slave_write_address[7:0];
  assign w_rd_a        = slave_read_address[7:0];
  assign w_wr_idx      = w_wr_a[7:4] - 4'd2;
  assign w_rd_idx      = w_rd_a[7:4] - 4'd2;
  assign w_wr_hit      = addr_hit(w_wr_a);
  assign w_rd_hit      = addr_hit(w_rd_a);
  assign w_unused_addr = ^{slave_write_address[31:8], slave_read_address[31:8]};

  always_comb begin
    w_nxt_status = r_int_status;
    w_nxt_mask   = r_int_mask;
    w_nxt_en     = r_en;
    w_wr_err     = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_nxt_src[i]   = r_src[i];
      w_nxt_dst[i]   = r_dst[i];
      w_nxt_size[i]  = r_size[i];
      w_nxt_cfg[i]   = r_cfg[i];
      w_nxt_state[i] = r_state[i];
    end
    if (slave_write_enable) begin
      if (!w_wr_hit) begin
        w_wr_err = 1'b1;
      end else if (w_wr_a[7:2] == 6'd0) begin
        w_nxt_status = r_int_status & ~slave_write_data;
      end else if (w_wr_a[7:2] == 6'd1) begin
        w_nxt_mask = slave_write_data & c_int_bits;
      end else begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (w_wr_idx == 4'(i)) begin
            if (r_state[i] != ST_IDLE) begin
              w_wr_err = 1'b1;
            end else begin
              case (w_wr_a[3:2])
                2'd0: begin
                  w_nxt_cfg[i] = slave_write_data[5:1];
                  w_nxt_en[i]  = 1'b0;
                  if (slave_write_data[0]) begin
                    if (r_size[i] != '0) begin
                      w_nxt_en[i]    = 1'b1;
                      w_nxt_state[i] = ST_START;
                    end else begin
                      w_wr_err              = 1'b1;
                      w_nxt_status[16 + i]  = 1'b1;
                    end
                  end
                end
                2'd1:    w_nxt_src[i]  = slave_write_data;
                2'd2:    w_nxt_dst[i]  = slave_write_data;
                default: w_nxt_size[i] = slave_write_data[SIZE_W-1:0];
              endcase
            end
          end
        end
      end
    end
    // Engine events are applied after the W1C so a same-cycle set wins
    for (int i = 0; i < CH_NUM; i++) begin
      case (r_state[i])
        ST_START: w_nxt_state[i] = ST_RUN;
        ST_RUN: begin
          if (ch_err[i]) begin
            w_nxt_status[16 + i] = 1'b1;
            w_nxt_en[i]          = 1'b0;
            w_nxt_state[i]       = ST_IDLE;
          end else if (ch_done[i]) begin
            w_nxt_status[i] = 1'b1;
            w_nxt_en[i]     = 1'b0;
            w_nxt_state[i]  = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads see post-write values, which gives the read-after-write bypass
  always_comb begin
    w_rd_val = '0;
    if (w_rd_a[7:2] == 6'd0) begin
      w_rd_val = w_nxt_status;
    end else if (w_rd_a[7:2] == 6'd1) begin
      w_rd_val = w_nxt_mask;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_rd_idx == 4'(i)) begin
          case (w_rd_a[3:2])
            2'd0:    w_rd_val = {23'd0, (w_nxt_state[i] != ST_IDLE), 2'd0,
                                 w_nxt_cfg[i], w_nxt_en[i]};
            2'd1:    w_rd_val = w_nxt_src[i];
            2'd2:    w_rd_val = w_nxt_dst[i];
            default: w_rd_val = 32'(w_nxt_size[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_int_status <= '0;
      r_int_mask   <= '0;
      r_en         <= '0;
      r_rd_data    <= '0;
      r_err        <= 1'b0;
      r_irq        <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_src[i]   <= '0;
        r_dst[i]   <= '0;
        r_size[i]  <= '0;
        r_cfg[i]   <= '0;
        r_state[i] <= ST_IDLE;
      end
    end else begin
      r_int_status <= w_nxt_status;
      r_int_mask   <= w_nxt_mask;
      r_en         <= w_nxt_en;
      r_rd_data    <= (slave_read_enable && w_rd_hit) ? w_rd_val : '0;
      r_err        <= w_wr_err | (slave_read_enable & ~w_rd_hit);
      r_irq        <= |(r_int_status & r_int_mask);
      for (int i = 0; i < CH_NUM; i++) begin
        r_src[i]   <= w_nxt_src[i];
        r_dst[i]   <= w_nxt_dst[i];
        r_size[i]  <= w_nxt_size[i];
        r_cfg[i]   <= w_nxt_cfg[i];
        r_state[i] <= w_nxt_state[i];
      end
    end
  end

  assign slave_read_data = r_rd_data;
  assign slave_error     = r_err;
  assign irq_o           = r_irq;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign ch_start[g]                  = (r_state[g] == ST_START);
    assign ch_src_addr[32*g +: 32]      = r_src[g];
    assign ch_dst_addr[32*g +: 32]      = r_dst[g];
    assign ch_size[SIZE_W*g +: SIZE_W]  = r_size[g];
    assign ch_ctrl[4*g +: 4]            = r_cfg[g][4:1];
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_regfile.sv
`default_nettype none
// ============================================================================
// tb_ahb_dma_regfile : directed self-checking bench for ahb_dma_regfile
// Revision           : 1.0
// ============================================================================
module tb_ahb_dma_regfile;

  localparam int CH_NUM = 4;
  localparam int SIZE_W = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     slave_write_enable = 1'b0;
  logic [31:0]              slave_write_address = '0;
  logic [31:0]              slave_write_data = '0;
  logic                     slave_read_enable = 1'b0;
  logic [31:0]              slave_read_address = '0;
  logic [31:0]              slave_read_data;
  logic                     slave_error;
  logic [CH_NUM-1:0]        ch_start;
  logic [32*CH_NUM-1:0]     ch_src_addr;
  logic [32*CH_NUM-1:0]     ch_dst_addr;
  logic [SIZE_W*CH_NUM-1:0] ch_size;
  logic [4*CH_NUM-1:0]      ch_ctrl;
  logic [CH_NUM-1:0]        ch_done = '0;
  logic [CH_NUM-1:0]        ch_err = '0;
  logic                     irq_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rdata;
  logic        rerr;

  always #5 clk_i = ~clk_i;

  ahb_dma_regfile #(.CH_NUM(CH_NUM), .SIZE_W(SIZE_W)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .slave_write_enable (slave_write_enable),
    .slave_write_address(slave_write_address),
    .slave_write_data   (slave_write_data),
    .slave_read_enable  (slave_read_enable),
    .slave_read_address (slave_read_address),
    .slave_read_data    (slave_read_data),
    .slave_error        (slave_error),
    .ch_start           (ch_start),
    .ch_src_addr        (ch_src_addr),
    .ch_dst_addr        (ch_dst_addr),
    .ch_size            (ch_size),
    .ch_ctrl            (ch_ctrl),
    .ch_done            (ch_done),
    .ch_err             (ch_err),
    .irq_o              (irq_o)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    slave_write_enable  = 1'b1;
    slave_write_address = a;
    slave_write_data    = d;
    @(posedge clk_i); #1;
    slave_write_enable  = 1'b0;
    slave_write_address = '0;
    slave_write_data    = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    slave_read_enable  = 1'b1;
    slave_read_address = a;
    @(posedge clk_i); #1;
    slave_read_enable  = 1'b0;
    slave_read_address = '0;
    d = slave_read_data;
    e = slave_error;
  endtask

  task automatic pulse(input logic [CH_NUM-1:0] dn, input logic [CH_NUM-1:0] er);
    ch_done = dn;
    ch_err  = er;
    @(posedge clk_i); #1;
    ch_done = '0;
    ch_err  = '0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    idle(3);
    n_checks++; if (slave_read_data !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected %h", slave_read_data, 32'h0); end
    n_checks++; if (slave_error !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", slave_error); end
    n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    n_checks++; if (ch_start !== 4'h0) begin n_errors++; $display("FAIL reset_start: got %h expected 0", ch_start); end
    n_checks++; if (ch_src_addr !== '0) begin n_errors++; $display("FAIL reset_src: got %h expected 0", ch_src_addr); end
    rst_i = 1'b0;
    rd(32'h0, rdata, rerr);
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_status: got %h expected 0", rdata); end
  endtask

  task automatic test_start;
    wr(32'h24, 32'h2000_0000);
    wr(32'h28, 32'h2000_1000);
    wr(32'h2C, 32'h0000_0010);
    wr(32'h20, 32'h0000_000D);
    n_checks++; if (ch_start !== 4'b0001) begin n_errors++; $display("FAIL start_pulse: got %b expected 0001", ch_start); end
    n_checks++; if (slave_error !== 1'b0) begin n_errors++; $display("FAIL start_err: got %b expected 0", slave_error); end
    n_checks++; if (ch_src_addr[31:0] !== 32'h2000_0000) begin n_errors++; $display("FAIL start_src: got %h expected 20000000", ch_src_addr[31:0]); end
    n_checks++; if (ch_dst_addr[31:0] !== 32'h2000_1000) begin n_errors++; $display("FAIL start_dst: got %h expected 20001000", ch_dst_addr[31:0]); end
    n_checks++; if (ch_size[15:0] !== 16'h0010) begin n_errors++; $display("FAIL start_size: got %h expected 0010", ch_size[15:0]); end
    n_checks++; if (ch_ctrl[3:0] !== 4'h3) begin n_errors++; $display("FAIL start_ctrl: got %h expected 3", ch_ctrl[3:0]); end
    rd(32'h20, rdata, rerr);
    n_checks++; if (rdata !== 32'h0000_010D) begin n_errors++; $display("FAIL start_busy: got %h expected 0000010d", rdata); end
    n_checks++; if (ch_start !== 4'b0000) begin n_errors++; $display("FAIL start_one_cycle: got %b expected 0000", ch_start); end
  endtask

  task automatic test_irq;
    wr(32'h04, 32'h1);
    pulse(4'b0001, 4'b0000);
    n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL irq_latency: got %b expected 0", irq_o); end
    idle(1);
    n_checks++; if (irq_o !== 1'b1) begin n_errors++; $display("FAIL irq_set: got %b expected 1", irq_o); end
    rd(32'h00, rdata, rerr);
    n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL irq_status: got %h expected 00000001", rdata); end
    rd(32'h20, rdata, rerr);
    n_checks++; if (rdata !== 32'h0000_000C) begin n_errors++; $display("FAIL done_csr: got %h expected 0000000c", rdata); end
    wr(32'h00, 32'h1);
    n_checks++; if (irq_o !== 1'b1) begin n_errors++; $display("FAIL irq_hold: got %b expected 1", irq_o); end
    idle(1);
    n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got %b expected 0", irq_o); end
  endtask

  task automatic test_size_zero;
    wr(32'h30, 32'h1);
    n_checks++; if (slave_error !== 1'b1) begin n_errors++; $display("FAIL sz0_err: got %b expected 1", slave_error); end
    n_checks++; if (ch_start !== 4'b0000) begin n_errors++; $display("FAIL sz0_start: got %b expected 0000", ch_start); end
    rd(32'h00, rdata, rerr);
    n_checks++; if (rdata !== 32'h0002_0000) begin n_errors++; $display("FAIL sz0_status: got %h expected 00020000", rdata); end
    n_checks++; if (rerr !== 1'b0) begin n_errors++; $display("FAIL sz0_err_once: got %b expected 0", rerr); end
    rd(32'h30, rdata, rerr);
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL sz0_csr: got %h expected 0", rdata); end
    n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL sz0_irq_masked: got %b expected 0", irq_o); end
    wr(32'h00, 32'h0002_0000);
  endtask

  task automatic test_busy_write;
    wr(32'h20, 32'h0D);
    idle(1);
    wr(32'h2C, 32'h55);
    n_checks++; if (slave_error !== 1'b1) begin n_errors++; $display("FAIL busy_size_err: got %b expected 1", slave_error); end
    rd(32'h2C, rdata, rerr);
    n_checks++; if (rdata !== 32'h10) begin n_errors++; $display("FAIL busy_size_kept: got %h expected 00000010", rdata); end
    n_checks++; if (ch_size[15:0] !== 16'h0010) begin n_errors++; $display("FAIL busy_size_port: got %h expected 0010", ch_size[15:0]); end
    wr(32'h20, 32'h0);
    n_checks++; if (slave_error !== 1'b1) begin n_errors++; $display("FAIL busy_csr_err: got %b expected 1", slave_error); end
    rd(32'h20, rdata, rerr);
    n_checks++; if (rdata !== 32'h0000_010D) begin n_errors++; $display("FAIL busy_no_abort: got %h expected 0000010d", rdata); end
    ch_done = 4'b0001;
    wr(32'h00, 32'h1);
    ch_done = 4'b0000;
    rd(32'h00, rdata, rerr);
    n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL set_beats_clear: got %h expected 00000001", rdata); end
    wr(32'h00, 32'h1);
    idle(2);
    n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL busy_irq_clear: got %b expected 0", irq_o); end
  endtask

  task automatic test_err_priority;
    wr(32'h20, 32'h0D);
    idle(1);
    pulse(4'b0001, 4'b0001);
    rd(32'h00, rdata, rerr);
    n_checks++; if (rdata !== 32'h0001_0000) begin n_errors++; $display("FAIL err_wins: got %h expected 00010000", rdata); end
    wr(32'h00, 32'h0001_0000);
    pulse(4'b0001, 4'b0000);
    rd(32'h00, rdata, rerr);
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL done_in_idle: got %h expected 0", rdata); end
  endtask

  task automatic test_back_to_back;
    slave_write_enable  = 1'b1;
    slave_write_address = 32'h44;
    slave_write_data    = 32'hA5A5_A5A4;
    slave_read_enable   = 1'b1;
    slave_read_address  = 32'h44;
    @(posedge clk_i); #1;
    slave_write_enable  = 1'b0;
    slave_read_enable   = 1'b0;
    n_checks++; if (slave_read_data !== 32'hA5A5_A5A4) begin n_errors++; $display("FAIL bypass: got %h expected a5a5a5a4", slave_read_data); end
    n_checks++; if (ch_src_addr[95:64] !== 32'hA5A5_A5A4) begin n_errors++; $display("FAIL src2_port: got %h expected a5a5a5a4", ch_src_addr[95:64]); end
    rd(32'h44, rdata, rerr);
    n_checks++; if (rdata !== 32'hA5A5_A5A4) begin n_errors++; $display("FAIL src2_read: got %h expected a5a5a5a4", rdata); end
  endtask

  task automatic test_unmapped;
    rd(32'h1C, rdata, rerr);
    n_checks++; if (rdata !== 32'h0 || rerr !== 1'b1) begin n_errors++; $display("FAIL unmapped_1c: got data %h err %b expected 0/1", rdata, rerr); end
    idle(1);
    n_checks++; if (slave_error !== 1'b0) begin n_errors++; $display("FAIL unmapped_err_drop: got %b expected 0", slave_error); end
    rd(32'h02, rdata, rerr);
    n_checks++; if (rdata !== 32'h0 || rerr !== 1'b1) begin n_errors++; $display("FAIL misaligned_02: got data %h err %b expected 0/1", rdata, rerr); end
    wr(32'h60, 32'h1234);
    n_checks++; if (slave_error !== 1'b1) begin n_errors++; $display("FAIL unmapped_wr60: got %b expected 1", slave_error); end
    wr(32'h06, 32'h0);
    rd(32'h04, rdata, rerr);
    n_checks++; if (rdata !== 32'h1) begin n_errors++; $display("FAIL misaligned_wr_dropped: got %h expected 00000001", rdata); end
  endtask

  task automatic test_reset_run;
    wr(32'h20, 32'h0D);
    idle(1);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    n_checks++; if (ch_start !== 4'h0 || ch_src_addr !== '0 || ch_size !== '0 || ch_ctrl !== '0) begin n_errors++; $display("FAIL rst_run_outputs: got start %h ctrl %h expected 0", ch_start, ch_ctrl); end
    pulse(4'b0001, 4'b0001);
    idle(1);
    n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL rst_run_irq: got %b expected 0", irq_o); end
    rd(32'h00, rdata, rerr);
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL rst_run_status: got %h expected 0", rdata); end
    rd(32'h20, rdata, rerr);
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL rst_run_csr: got %h expected 0", rdata); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_irq();
    test_size_zero();
    test_busy_write();
    test_err_priority();
    test_back_to_back();
    test_unmapped();
    test_reset_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
